// File: rtl/conv_stream_feeder_pkg.sv
// Shared constants for the convolution stream feeder: word counts, FSM
// state encoding and the default data width.
`ifndef CONV_BIT_LENGTH
`define CONV_BIT_LENGTH 16
`endif

package conv_stream_feeder_pkg;
  localparam int DEFAULT_BIT_LENGTH = `CONV_BIT_LENGTH;
  localparam int WINDOW_WORDS       = 9;
  localparam int WORD_COUNT         = 2 * WINDOW_WORDS;
  localparam int IDX_W              = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND   = 3'd1;
  localparam logic [2:0] ST_CSTART = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;
endpackage

// File: rtl/conv_feed_buffer.sv
// 18-entry window+kernel register file: sequential load port with a fill
// count, and an asynchronous read port addressed by the streaming index.
module conv_feed_buffer
  import conv_stream_feeder_pkg::*;
#(
  parameter int BIT_LENGTH = DEFAULT_BIT_LENGTH
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [BIT_LENGTH-1:0] wr_data,
  input  logic                  cnt_clr,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [BIT_LENGTH-1:0] rd_data,
  output logic [IDX_W-1:0]      count
);
  logic [BIT_LENGTH-1:0] mem_q [WORD_COUNT];
  logic [BIT_LENGTH-1:0] mem_d [WORD_COUNT];
  logic [IDX_W-1:0]      count_q;
  logic [IDX_W-1:0]      count_d;

  // Contents need no reset: count gates both what is loaded and what is sent.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_COUNT; gi++) begin : g_entry
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (wr_en && (count_q == IDX_W'(gi))) mem_d[gi] = wr_data;
      end

      always_ff @(posedge clk) begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (cnt_clr)    count_d = '0;
    else if (wr_en) count_d = count_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count   = count_q;
  assign rd_data = (rd_idx < IDX_W'(WORD_COUNT)) ? mem_q[rd_idx] : '0;
endmodule

// File: rtl/conv_stream_feeder.sv
// Feeds one buffered 3x3 window and kernel into the convolution accelerator
// FIFO, starts it, and returns the final sum over a valid/ready port.
module conv_stream_feeder
  import conv_stream_feeder_pkg::*;
#(
  parameter int BIT_LENGTH = DEFAULT_BIT_LENGTH,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  load_valid,
  input  logic [BIT_LENGTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  start,
  output logic                  busy,
  output logic [BIT_LENGTH-1:0] acc_data,
  output logic                  acc_wr,
  input  logic                  acc_full,
  output logic                  acc_cstart,
  input  logic                  acc_cready,
  input  logic [BIT_LENGTH-1:0] acc_finalsum,
  output logic                  res_valid,
  output logic [BIT_LENGTH-1:0] res_data,
  input  logic                  res_ready,
  output logic                  err_timeout
);
  localparam int TIMER_W = $clog2(TIMEOUT);

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [BIT_LENGTH-1:0] res_data_q, res_data_d;
  logic                  err_q, err_d;
  logic                  cnt_clr;
  logic [IDX_W-1:0]      count;
  logic [BIT_LENGTH-1:0] buf_rd;

  assign load_ready = (state_q == ST_IDLE) && (count < IDX_W'(WORD_COUNT));
  assign acc_wr     = (state_q == ST_SEND) && !acc_full;
  assign acc_data   = (state_q == ST_SEND) ? buf_rd : '0;
  assign acc_cstart = (state_q == ST_CSTART);
  assign busy       = (state_q == ST_SEND) || (state_q == ST_CSTART) || (state_q == ST_WAIT);
  assign res_valid  = (state_q == ST_RESULT);
  assign res_data   = res_data_q;
  assign err_timeout = err_q;

  conv_feed_buffer #(.BIT_LENGTH(BIT_LENGTH)) u_buf (
    .clk     (Clk),
    .srst    (Rst),
    .wr_en   (load_valid && load_ready),
    .wr_data (load_data),
    .cnt_clr (cnt_clr),
    .rd_idx  (idx_q),
    .rd_data (buf_rd),
    .count   (count)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    cnt_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (count == IDX_W'(WORD_COUNT))) begin
          state_d = ST_SEND;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_SEND: begin
        if (acc_wr) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WORD_COUNT - 1)) state_d = ST_CSTART;
        end
      end
      ST_CSTART: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the expiry cycle still counts as success.
        if (acc_cready) begin
          res_data_d = acc_finalsum;
          state_d    = ST_RESULT;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end
endmodule
